disaggregator: RTL and testbench

//  Splits one wide word of FETCH_WIDTH packed DATA_WIDTH slots into FETCH_WIDTH

---
 rtl/ann_io_pkg.sv | 15 +
 rtl/disaggregator.sv | 63 ++++++
 tb/tb_disaggregator.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ann_io_pkg.sv
// rtl/ann_io_pkg.sv - shared ANN I/O widths, slot index type and disaggregator state encoding
package ann_io_pkg;

    localparam int ANN_DATA_WIDTH  = 11;
    localparam int ANN_FETCH_WIDTH = 2;
    localparam int ANN_SLOT_IDX_W  = $clog2(ANN_FETCH_WIDTH);

    typedef logic [ANN_SLOT_IDX_W-1:0] slot_idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } disagg_state_t;

endpackage

// File: rtl/disaggregator.sv
// rtl/disaggregator.sv - splits one wide word into FETCH_WIDTH narrow words, one per accepted cycle
// Optional macro DISAGG_MSB_FIRST_EN emits the most significant slot first.
module disaggregator
    import ann_io_pkg::*;
#(
    parameter int DATA_WIDTH  = ANN_DATA_WIDTH,
    parameter int FETCH_WIDTH = ANN_FETCH_WIDTH
) (
    input  logic                              clk,
    input  logic                              wrst_n,
    input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data,
    input  logic                              sender_empty_n,
    output logic                              sender_deq,
    output logic [DATA_WIDTH-1:0]             receiver_data,
    input  logic                              receiver_full_n,
    output logic                              receiver_enq,
    output logic                              busy
);

    localparam int              CW       = $clog2(FETCH_WIDTH);
    localparam logic [CW-1:0]   LAST_CNT = CW'(FETCH_WIDTH - 1);

    disagg_state_t                        state;
    logic [CW-1:0]                        cnt;
    logic [CW-1:0]                        sel;
    logic [FETCH_WIDTH-1:0][DATA_WIDTH-1:0] hold;
    logic                                 last;

    assign last = (cnt == LAST_CNT);

    // Handshakes are gated by reset so nothing moves while wrst_n is low.
    assign receiver_enq = wrst_n & (state == SEND) & receiver_full_n;
    assign sender_deq   = wrst_n & sender_empty_n & ((state == IDLE) | (last & receiver_enq));
    assign busy         = (state == SEND);

`ifdef DISAGG_MSB_FIRST_EN
    assign sel = LAST_CNT - cnt;
`else
    assign sel = cnt;
`endif

    assign receiver_data = hold[sel];

    always_ff @(posedge clk) begin
        if (!wrst_n) begin
            state <= IDLE;
            cnt   <= '0;
            hold  <= '0;
        end else if (sender_deq) begin
            // Covers both IDLE load and back-to-back reload on the last slot.
            hold  <= sender_data;
            cnt   <= '0;
            state <= SEND;
        end else if (receiver_enq) begin
            if (last) begin
                state <= IDLE;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_disaggregator.sv
// tb/tb_disaggregator.sv - scoreboard bench for disaggregator (DATA_WIDTH=11, FETCH_WIDTH=2)
module tb_disaggregator;

    localparam int DW = 11;
    localparam int FW = 2;
    localparam int MAXC = 8192;

    logic              clk = 1'b0;
    logic              wrst_n;
    logic [FW*DW-1:0]  sender_data;
    logic              sender_empty_n;
    logic              sender_deq;
    logic [DW-1:0]     receiver_data;
    logic              receiver_full_n;
    logic              receiver_enq;
    logic              busy;

    disaggregator #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW)) dut (
        .clk             (clk),
        .wrst_n          (wrst_n),
        .sender_data     (sender_data),
        .sender_empty_n  (sender_empty_n),
        .sender_deq      (sender_deq),
        .receiver_data   (receiver_data),
        .receiver_full_n (receiver_full_n),
        .receiver_enq    (receiver_enq),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int bp_mode = 0;

    logic [FW*DW-1:0] src_q[$];
    logic [DW-1:0]    exp_q[$];
    int               deq_log[$];
    int               enq_cyc[$];
    logic [DW-1:0]    enq_dat[$];
    logic             busy_at [MAXC];

    logic             prev_stall = 1'b0;
    logic [DW-1:0]    prev_data  = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Drive inputs on the falling edge, sample just before the rising edge.
    always @(negedge clk) begin
        sender_empty_n  = (src_q.size() > 0);
        sender_data     = (src_q.size() > 0) ? src_q[0] : '0;
        receiver_full_n = (bp_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        #4;
        if (cyc < MAXC) busy_at[cyc] = busy;
        if (wrst_n === 1'b1) begin
            if (prev_stall) check("stall_hold", 32'(receiver_data), 32'(prev_data));
            prev_stall = busy & ~receiver_full_n;
            prev_data  = receiver_data;
        end else begin
            prev_stall = 1'b0;
        end
        if (receiver_enq === 1'b1) begin
            enq_cyc.push_back(cyc);
            enq_dat.push_back(receiver_data);
            if (exp_q.size() == 0) check("enq_unexpected", 32'(1), 32'(0));
            else check("sb_data", 32'(receiver_data), 32'(exp_q.pop_front()));
        end
        if (sender_deq === 1'b1) begin
            logic [FW*DW-1:0] w;
            w = src_q.pop_front();
            deq_log.push_back(cyc);
            for (int s = 0; s < FW; s++) begin
`ifdef DISAGG_MSB_FIRST_EN
                exp_q.push_back(w[(FW-1-s)*DW +: DW]);
`else
                exp_q.push_back(w[s*DW +: DW]);
`endif
            end
        end
    end

    task automatic clear_logs();
        deq_log.delete();
        enq_cyc.delete();
        enq_dat.delete();
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(posedge clk);
            if (src_q.size() == 0 && exp_q.size() == 0 && busy === 1'b0) break;
        end
        check({tag, "_drain_timeout"}, 32'(i < budget), 32'(1));
    endtask

    initial begin
        logic [DW-1:0] first_exp;
        logic [DW-1:0] second_exp;
        int n;
        int i;
        int base;
`ifdef DISAGG_MSB_FIRST_EN
        first_exp = 11'd5; second_exp = 11'd3;
`else
        first_exp = 11'd3; second_exp = 11'd5;
`endif
        wrst_n = 1'b0;
        src_q.push_back({11'd5, 11'd3});

        // Reset with a word waiting: nothing may move.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #2;
            check("rst_deq",  32'(sender_deq),    32'(0));
            check("rst_enq",  32'(receiver_enq),  32'(0));
            check("rst_data", 32'(receiver_data), 32'(0));
            check("rst_busy", 32'(busy),          32'(0));
        end
        clear_logs();
        wrst_n = 1'b1;
        wait_drain("single", 50);
        check("single_ndeq", 32'(deq_log.size()), 32'(1));
        check("single_nenq", 32'(enq_cyc.size()), 32'(2));
        if (deq_log.size() == 1 && enq_cyc.size() == 2) begin
            n = deq_log[0];
            check("single_lat0",  32'(enq_cyc[0]), 32'(n + 1));
            check("single_lat1",  32'(enq_cyc[1]), 32'(n + 2));
            check("single_d0",    32'(enq_dat[0]), 32'(first_exp));
            check("single_d1",    32'(enq_dat[1]), 32'(second_exp));
            check("single_busy2", 32'(busy_at[n + 2]), 32'(1));
            check("single_busy3", 32'(busy_at[n + 3]), 32'(0));
        end

        // Back-to-back words, no bubble between them.
        clear_logs();
        src_q.push_back({11'd2, 11'd1});
        src_q.push_back({11'd4, 11'd3});
        wait_drain("b2b", 50);
        check("b2b_nenq", 32'(enq_cyc.size()), 32'(4));
        check("b2b_ndeq", 32'(deq_log.size()), 32'(2));
        if (enq_cyc.size() == 4 && deq_log.size() == 2) begin
            for (int k = 1; k < 4; k++) check("b2b_consec", 32'(enq_cyc[k]), 32'(enq_cyc[0] + k));
            check("b2b_deq2", 32'(deq_log[1]), 32'(enq_cyc[1]));
`ifndef DISAGG_MSB_FIRST_EN
            for (int k = 0; k < 4; k++) check("b2b_data", 32'(enq_dat[k]), 32'(k + 1));
`endif
        end

        // Reset after the first slot of {5,3} has gone out.
        clear_logs();
        src_q.push_back({11'd5, 11'd3});
        for (i = 0; i < 50 && enq_cyc.size() < 1; i++) @(posedge clk);
        check("mid_wait_timeout", 32'(i < 50), 32'(1));
        #2;
        wrst_n = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        check("mid_busy", 32'(busy), 32'(0));
        check("mid_nenq", 32'(enq_cyc.size()), 32'(1));
        exp_q.delete();
        wrst_n = 1'b1;
        clear_logs();
        src_q.push_back({11'd8, 11'd7});
        wait_drain("post_rst", 50);
        check("post_rst_nenq", 32'(enq_cyc.size()), 32'(2));
        if (enq_cyc.size() == 2) begin
`ifdef DISAGG_MSB_FIRST_EN
            check("post_rst_d0", 32'(enq_dat[0]), 32'(8));
            check("post_rst_d1", 32'(enq_dat[1]), 32'(7));
`else
            check("post_rst_d0", 32'(enq_dat[0]), 32'(7));
            check("post_rst_d1", 32'(enq_dat[1]), 32'(8));
`endif
        end

        // Random words under 50% backpressure, scoreboard checks order/content.
        clear_logs();
        bp_mode = 1;
        base = n_cmp;
        for (int k = 0; k < 200; k++) src_q.push_back(22'($urandom));
        wait_drain("rand", 3000);
        check("rand_nenq", 32'(enq_cyc.size()), 32'(400));
        check("rand_ndeq", 32'(deq_log.size()), 32'(200));
        check("rand_exp_empty", 32'(exp_q.size()), 32'(0));
        check("rand_compared", 32'(n_cmp - base > 400), 32'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
